// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM fade LED array.
// Channels and the array top both import this package.
package pwm_pkg;

   localparam int DEF_NUM_CH     = 3;
   localparam int DEF_DUTY_W     = 8;
   localparam int DEF_PRESCALE   = 47;
   localparam bit DEF_ACTIVE_LOW = 1'b1;
   localparam int DEF_FADE_STEP  = 1;

   typedef enum logic {
      MODE_JUMP = 1'b0,
      MODE_FADE = 1'b1
   } pwm_mode_e;

   // Index width that stays at least one bit wide for single-entry ranges.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM LED channel: target/mode/current duty registers, fade stepping,
// duty compare against the shared period counter, and registered LED drive.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int DUTY_W     = DEF_DUTY_W,
   parameter int FADE_STEP  = DEF_FADE_STEP,
   parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DUTY_W-1:0] wr_duty,
   input  logic              wr_fade,
   input  logic              commit,
   input  logic [DUTY_W-1:0] count,
   output logic              led_out,
   output logic              busy
);

   // A step larger than the whole duty range behaves like a jump, so clamp it
   // to keep the widened arithmetic from truncating.
   localparam int STEP_CLAMP = (FADE_STEP > (1 << DUTY_W)) ? (1 << DUTY_W) : FADE_STEP;
   localparam logic [DUTY_W:0] STEP_EXT = (DUTY_W + 1)'(STEP_CLAMP);

   logic [DUTY_W-1:0] target;
   logic [DUTY_W-1:0] cur_duty;
   logic [DUTY_W-1:0] next_duty;
   logic [DUTY_W:0]   step_up;
   logic [DUTY_W:0]   step_dn;
   pwm_mode_e         mode;

   always_comb begin
      next_duty = target;
      step_up   = {1'b0, cur_duty} + STEP_EXT;
      step_dn   = ({1'b0, cur_duty} > STEP_EXT) ? ({1'b0, cur_duty} - STEP_EXT) : '0;
      if (mode == MODE_FADE) begin
         if (target > cur_duty) begin
            next_duty = (step_up > {1'b0, target}) ? target : step_up[DUTY_W-1:0];
         end else if (target < cur_duty) begin
            next_duty = (step_dn < {1'b0, target}) ? target : step_dn[DUTY_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         target   <= '0;
         mode     <= MODE_JUMP;
         cur_duty <= '0;
         led_out  <= ACTIVE_LOW;
      end else begin
         if (wr_en) begin
            target <= wr_duty;
            mode   <= pwm_mode_e'(wr_fade);
         end
         if (commit) begin
            cur_duty <= next_duty;
         end
         led_out <= (count < cur_duty) ^ ACTIVE_LOW;
      end
   end

   assign busy = (cur_duty != target);

endmodule

// File: rtl/pwm_fade_array.sv
// Array of independent PWM LED channels sharing one prescaler and period
// counter; duty writes are staged and committed at each period boundary.
module pwm_fade_array
   import pwm_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DUTY_W     = DEF_DUTY_W,
   parameter int PRESCALE   = DEF_PRESCALE,
   parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW,
   parameter int FADE_STEP  = DEF_FADE_STEP
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   input  logic [idx_width(NUM_CH)-1:0]    wr_ch,
   input  logic [DUTY_W-1:0]               wr_duty,
   input  logic                            wr_fade,
   output logic [NUM_CH-1:0]               led_out,
   output logic [NUM_CH-1:0]               busy,
   output logic                            period_start
);

   localparam int CH_W = idx_width(NUM_CH);
   localparam int PS_W = idx_width(PRESCALE);
   localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [DUTY_W-1:0] CNT_LAST = '1;

   logic [PS_W-1:0]   prescale_cnt;
   logic [DUTY_W-1:0] period_cnt;
   logic              tick;
   logic              boundary;
   logic              wr_fire;

   assign tick     = (prescale_cnt == PS_LAST);
   assign boundary = tick && (period_cnt == CNT_LAST);
   assign wr_ready = !rst && !boundary;
   assign wr_fire  = wr_valid && wr_ready;

   // Shared timebase; period_start trails the boundary cycle by one clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescale_cnt <= '0;
         period_cnt   <= '0;
         period_start <= 1'b0;
      end else begin
         prescale_cnt <= tick ? '0 : prescale_cnt + 1'b1;
         if (tick) begin
            period_cnt <= period_cnt + 1'b1;
         end
         period_start <= boundary;
      end
   end

   // Out-of-range channel indices match no instance, so they complete the
   // handshake without touching any state.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pwm_channel #(
         .DUTY_W     (DUTY_W),
         .FADE_STEP  (FADE_STEP),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_fire && (wr_ch == CH_W'(i))),
         .wr_duty (wr_duty),
         .wr_fade (wr_fade),
         .commit  (boundary),
         .count   (period_cnt),
         .led_out (led_out[i]),
         .busy    (busy[i])
      );
   end

endmodule
